// File: rtl/matrix_entry_loader.sv
// Sequential operand writer: debounces a key and writes one element of A then B per press.
// Optional build macro MATLOAD_WRAP_EN makes a press in DONE restart loading at A[0][0].
module matrix_entry_loader #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned N               = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  localparam int unsigned IDX_W          = $clog2(N),
  localparam int unsigned CNT_W          = $clog2(2 * N * N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_n,
  input  logic [WIDTH-1:0] sw,
  output logic             wr_en,
  output logic             wr_sel,
  output logic [IDX_W-1:0] wr_row,
  output logic [IDX_W-1:0] wr_col,
  output logic [WIDTH-1:0] wr_data,
  output logic [CNT_W-1:0] cur_index,
  output logic             done
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DbW-1:0]   DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] LastA   = CNT_W'(N * N - 1);
  localparam logic [CNT_W-1:0] LastB   = CNT_W'(2 * N * N - 1);
  localparam logic [CNT_W-1:0] Total   = CNT_W'(2 * N * N);

  typedef enum logic [1:0] {
    StLoadA = 2'd0,
    StLoadB = 2'd1,
    StDone  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchronizer and debouncer
  // ---------------------------------------------------------------------------
  logic [1:0]     sync_q;
  logic           key_sync;
  logic           db_level_q, db_level_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           press_q, press_d;

  assign key_sync = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_n};
    end
  end

  // The level flips once DEBOUNCE_CYCLES consecutive mismatching samples have been seen.
  always_comb begin
    db_cnt_d   = '0;
    db_level_d = db_level_q;
    press_d    = 1'b0;
    if (key_sync != db_level_q) begin
      if (db_cnt_q == DbLast) begin
        db_level_d = key_sync;
        press_d    = ~key_sync;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_level_q <= 1'b1;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
    end else begin
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Load sequencer
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic             wr_en_q, wr_en_d;
  logic             wr_sel_q, wr_sel_d;
  logic [IDX_W-1:0] wr_row_q, wr_row_d;
  logic [IDX_W-1:0] wr_col_q, wr_col_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  // Row/col of the next element within its matrix, kept alongside idx_q to avoid a divider.
  logic [IDX_W-1:0] ptr_row_q, ptr_row_d;
  logic [IDX_W-1:0] ptr_col_q, ptr_col_d;

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_sel_d  = wr_sel_q;
    wr_row_d  = wr_row_q;
    wr_col_d  = wr_col_q;
    wr_data_d = wr_data_q;
    idx_d     = idx_q;
    done_d    = done_q;
    ptr_row_d = ptr_row_q;
    ptr_col_d = ptr_col_q;

    unique case (state_q)
      StLoadA, StLoadB: begin
        if (press_q) begin
          wr_en_d   = 1'b1;
          wr_sel_d  = (state_q == StLoadB);
          wr_row_d  = ptr_row_q;
          wr_col_d  = ptr_col_q;
          wr_data_d = sw;
          idx_d     = idx_q + CNT_W'(1);

          if (ptr_col_q == IdxLast) begin
            ptr_col_d = '0;
            if (ptr_row_q == IdxLast) begin
              ptr_row_d = '0;
            end else begin
              ptr_row_d = ptr_row_q + IDX_W'(1);
            end
          end else begin
            ptr_col_d = ptr_col_q + IDX_W'(1);
          end

          if (state_q == StLoadA && idx_q == LastA) begin
            state_d = StLoadB;
          end
          if (state_q == StLoadB && idx_q == LastB) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end

      StDone: begin
`ifdef MATLOAD_WRAP_EN
        // The restarting press itself writes A[0][0].
        if (press_q) begin
          wr_en_d   = 1'b1;
          wr_sel_d  = 1'b0;
          wr_row_d  = '0;
          wr_col_d  = '0;
          wr_data_d = sw;
          idx_d     = CNT_W'(1);
          ptr_row_d = '0;
          ptr_col_d = IDX_W'(1);
          done_d    = 1'b0;
          state_d   = StLoadA;
        end
`endif
      end

      default: begin
        state_d = StLoadA;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLoadA;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_data_q <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      ptr_row_q <= '0;
      ptr_col_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_sel_q  <= wr_sel_d;
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
      wr_data_q <= wr_data_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      ptr_row_q <= ptr_row_d;
      ptr_col_q <= ptr_col_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_sel    = wr_sel_q;
  assign wr_row    = wr_row_q;
  assign wr_col    = wr_col_q;
  assign wr_data   = wr_data_q;
  assign cur_index = idx_q;
  assign done      = done_q;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  done_tracks_index: assert property (@(posedge clk) disable iff (rst)
    done_q == (idx_q == Total));

  strobe_single_cycle: assert property (@(posedge clk) disable iff (rst)
    wr_en_q |=> !wr_en_q);

endmodule

// File: tb/tb_matrix_entry_loader.sv
// Directed bench for matrix_entry_loader with N=2, WIDTH=8, DEBOUNCE_CYCLES=4.
// Observes every wr_en cycle in a log and checks contents, counts and timing.
module tb_matrix_entry_loader;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N     = 2;
  localparam int unsigned DB    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_n = 1'b1;
  logic [7:0] sw = 8'd0;
  logic       wr_en;
  logic       wr_sel;
  logic [0:0] wr_row;
  logic [0:0] wr_col;
  logic [7:0] wr_data;
  logic [3:0] cur_index;
  logic       done;

  matrix_entry_loader #(
    .WIDTH           (WIDTH),
    .N               (N),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .sw        (sw),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .cur_index (cur_index),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       sel;
    logic       row;
    logic       col;
    logic [7:0] data;
    int         at;
  } wr_t;

  wr_t wq[$];

  always @(negedge clk) begin
    if (wr_en) wq.push_back('{wr_sel, wr_row[0], wr_col[0], wr_data, cyc});
  end

  typedef struct {
    logic [7:0] sw;
    logic       sel;
    logic       row;
    logic       col;
    logic [3:0] idx;
    logic       done;
  } vec_t;

  vec_t tbl[8];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [7:0] v);
    sw    = v;
    key_n = 1'b0;
    tick(DB + 8);
    key_n = 1'b1;
    tick(DB + 8);
  endtask

  task automatic check_write(input string name, input int base, input logic sel,
                             input logic row, input logic col, input logic [7:0] data);
    check({name, " count"}, wq.size() - base, 1);
    if (wq.size() > base) begin
      check({name, " sel"}, wq[base].sel, sel);
      check({name, " row"}, wq[base].row, row);
      check({name, " col"}, wq[base].col, col);
      check({name, " data"}, wq[base].data, data);
    end
  endtask

  int base;
  int m;

  initial begin
    tbl[0] = '{8'd4, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0};
    tbl[1] = '{8'd5, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0};
    tbl[2] = '{8'd2, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0};
    tbl[3] = '{8'd6, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0};
    tbl[4] = '{8'd1, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0};
    tbl[5] = '{8'd3, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0};
    tbl[6] = '{8'd7, 1'b1, 1'b1, 1'b0, 4'd7, 1'b0};
    tbl[7] = '{8'd2, 1'b1, 1'b1, 1'b1, 4'd8, 1'b1};

    // Reset and idle
    #1;
    tick(2);
    rst = 1'b0;
    tick(20);
    check("s1 wr_en", wr_en, 0);
    check("s1 wr_sel", wr_sel, 0);
    check("s1 wr_row", wr_row, 0);
    check("s1 wr_col", wr_col, 0);
    check("s1 wr_data", wr_data, 0);
    check("s1 cur_index", cur_index, 0);
    check("s1 done", done, 0);
    check("s1 no writes", wq.size(), 0);

    // Eight clean presses fill A then B
    for (int i = 0; i < 8; i++) begin
      base = wq.size();
      press(tbl[i].sw);
      check_write($sformatf("s2 v%0d", i), base, tbl[i].sel, tbl[i].row, tbl[i].col,
                  tbl[i].sw);
      check($sformatf("s2 v%0d cur_index", i), cur_index, tbl[i].idx);
      check($sformatf("s2 v%0d done", i), done, tbl[i].done);
    end

    // Outputs hold while sw wanders
    sw = 8'hAA;
    tick(5);
    check("hold wr_en", wr_en, 0);
    check("hold wr_sel", wr_sel, 1);
    check("hold wr_row", wr_row, 1);
    check("hold wr_col", wr_col, 1);
    check("hold wr_data", wr_data, 2);

    // Ninth press in DONE
    base = wq.size();
    press(8'd9);
`ifdef MATLOAD_WRAP_EN
    check_write("s6 wrap", base, 1'b0, 1'b0, 1'b0, 8'd9);
    check("s6 done", done, 0);
    check("s6 cur_index", cur_index, 1);
`else
    check("s6 no write", wq.size() - base, 0);
    check("s6 done", done, 1);
    check("s6 cur_index", cur_index, 8);
`endif

    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    check("post-rst cur_index", cur_index, 0);
    check("post-rst done", done, 0);

    // Latency and long hold
    base  = wq.size();
    sw    = 8'h11;
    m     = cyc;
    key_n = 1'b0;
    tick(100);
    check_write("s3 held", base, 1'b0, 1'b0, 1'b0, 8'h11);
    if (wq.size() > base) check("s3 latency", wq[base].at, m + DB + 3);
    key_n = 1'b1;
    tick(12);
    check("s3 release silent", wq.size() - base, 1);
    check("s3 cur_index", cur_index, 1);

    // Bounce before a stable low
    base  = wq.size();
    sw    = 8'h22;
    key_n = 1'b1; tick(1);
    key_n = 1'b0; tick(1);
    key_n = 1'b1; tick(1);
    key_n = 1'b0; tick(1);
    key_n = 1'b1; tick(1);
    m     = cyc;
    key_n = 1'b0;
    tick(DB + 12);
    check_write("s4 bounce", base, 1'b0, 1'b0, 1'b1, 8'h22);
    if (wq.size() > base) check("s4 latency", wq[base].at, m + DB + 3);
    key_n = 1'b1;
    tick(12);
    check("s4 cur_index", cur_index, 2);

    press(8'h33);
    check("s5 pre cur_index", cur_index, 3);

    // Reset in the middle of a debounce drops that press
    base  = wq.size();
    sw    = 8'h55;
    key_n = 1'b0;
    tick(3);
    rst   = 1'b1;
    key_n = 1'b1;
    tick(1);
    rst   = 1'b0;
    tick(15);
    check("s5 press lost", wq.size() - base, 0);
    check("s5 cur_index", cur_index, 0);
    base = wq.size();
    press(8'h44);
    check_write("s5 restart", base, 1'b0, 1'b0, 1'b0, 8'h44);
    check("s5 restart cur_index", cur_index, 1);
    check("s5 restart done", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/matrix_entry_loader.md
Name: matrix_entry_loader

Overview:
- Sequential operand writer for the matrix multiplier on the board.
- The user dials element values on the slide switches and presses a key once per element.
- The block debounces the key, walks A then B in row-major order and issues one write strobe per element, with row/col/matrix-select, to the matrix storage.
- Progress and completion are exported for LED/7-seg display.

Parameters:
- WIDTH, 8, element width in bits; also the width of sw and wr_data.
- N, 2, matrix dimension (N x N); legal N >= 2.
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required to accept a key level change; legal >= 1.
- Derived localparams:
  - IDX_W = $clog2(N).
  - CNT_W = $clog2(2*N*N+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_n  in  1  raw pushbutton, active-low, asynchronous to clk, bouncing.
- sw  in  WIDTH  element value to load.
- wr_en  out  1  one-cycle write strobe.
- wr_sel  out  1  0 = matrix A, 1 = matrix B.
- wr_row  out  IDX_W  row of the element being written.
- wr_col  out  IDX_W  column of the element being written.
- wr_data  out  WIDTH  element value.
- cur_index  out  CNT_W  flat index of the next element, 0..2*N*N.
- done  out  1  high once all 2*N*N elements are written.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high and has priority over all other activity.
- Reset values:
  - wr_en = 0, wr_sel = 0, wr_row = 0, wr_col = 0, wr_data = 0, cur_index = 0, done = 0.
  - State = LOAD_A.
  - Synchronizer flops = 1, debounced level = 1 (released), debounce counter = 0.
- Input synchronizer: key_n passes through a 2-flop synchronizer.
- Debouncer:
  - While the synchronized level differs from the debounced level, the counter increments each cycle. Any cycle where they match clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronized level and the counter clears.
  - A bounce resets the count.
- Press detection:
  - A press is a 1->0 transition of the debounced level, which is a one-cycle internal pulse.
  - Release transitions generate nothing.
- Latency: if key_n is low and stable from clock edge E0, wr_en is high for exactly the cycle following edge E0+DEBOUNCE_CYCLES+2.
- FSM states: LOAD_A, LOAD_B, DONE.
- Press in LOAD_A or LOAD_B:
  - On the registered edge, drive wr_en = 1, wr_sel = (state == LOAD_B), wr_row = cur_index[..]/N within the matrix, wr_col = within-matrix index mod N, and wr_data = sw sampled at that same edge.
  - cur_index then increments.
  - cur_index == N*N-1 in LOAD_A moves to LOAD_B.
  - cur_index == 2*N*N-1 in LOAD_B moves to DONE; done = 1 and cur_index = 2*N*N.
- Output hold: wr_row, wr_col, wr_sel and wr_data hold their last values when wr_en is 0.
- Press in DONE: ignored (see the optional feature). No wr_en, state held.
- Key held indefinitely: only one press is generated per debounced fall.
- Key held through reset: after reset the debounced level is 1, so a key still held counts as a press after debounce. This is intended.
- Reset mid-debounce or mid-matrix: any pending press is discarded and loading restarts at A[0][0].
- sw changes between presses: no effect on outputs. Only the value at the press edge is written.

Optional Feature:
- Macro: MATLOAD_WRAP_EN.
- Defined: a press in DONE restarts the sequence. That same press writes A[0][0] (wr_en = 1, wr_sel = 0, wr_row = 0, wr_col = 0, wr_data = sw), sets cur_index = 1, state = LOAD_A and done = 0.
- Undefined: DONE is terminal until rst; presses in DONE produce nothing.

Test Plan:
- Bench settings: N = 2, WIDTH = 8, DEBOUNCE_CYCLES = 4.
- Scenario 1: rst high 2 cycles, then low, idle 20 cycles -> all outputs 0, no wr_en, cur_index = 0.
- Scenario 2: eight clean presses with sw = 4, 5, 2, 6, 1, 3, 7, 2 -> eight single-cycle wr_en pulses.
  - (sel, row, col, data) sequence: (0,0,0,4) (0,0,1,5) (0,1,0,2) (0,1,1,6) (1,0,0,1) (1,0,1,3) (1,1,0,7) (1,1,1,2).
  - done = 1 and cur_index = 8 after the last write.
- Scenario 3: key_n low from edge E0 with no bounce -> wr_en high exactly in the cycle after edge E0+6; key held 100 cycles -> exactly one wr_en.
- Scenario 4: bounce of key_n 1-0-1-0-1 at 1-cycle intervals, then low and stable -> exactly one wr_en, DEBOUNCE_CYCLES+3 cycles after the final stable low.
- Scenario 5: after 3 writes, rst pulsed during a debounce in progress -> that press is lost; the next press writes (0,0,0,sw) and cur_index = 1.
- Scenario 6: ninth press in DONE.
  - Without MATLOAD_WRAP_EN: no wr_en, done stays 1.
  - With MATLOAD_WRAP_EN and sw = 9: wr_en writes (0,0,0,9), done = 0, cur_index = 1.
